// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the fetch-side redirect logic.
//   XLEN / RESET_PC : default datapath width and PC reset value
//   word_t          : one datapath word
//   redir_state_t   : redirect FSM states (RUN, SQUASH)
package pipe_pkg;
  localparam int              XLEN     = 32;
  localparam logic [XLEN-1:0] RESET_PC = '0;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } redir_state_t;
endpackage

// File: rtl/pc_target_calc.sv
// Branch/jump target calculator (purely combinational).
//   base_i     : PC of the EX instruction, or rs1 for JALR
//   offset_i   : sign-extended immediate
//   target_o   : (base_i + offset_i) mod 2^XLEN with bit0 cleared
//   misalign_o : bit1 of the target (not 4-byte aligned)
module pc_target_calc #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] base_i,
  input  logic [XLEN-1:0] offset_i,
  output logic [XLEN-1:0] target_o,
  output logic            misalign_o
);
  logic [XLEN-1:0] sum;

  assign sum = base_i + offset_i;
  // The JALR bit0 clear is applied to every target so branch and jump share one path.
  assign target_o   = {sum[XLEN-1:1], 1'b0};
  assign misalign_o = sum[1];
endmodule

// File: rtl/pc_redirect_unit.sv
// Program counter owner and fetch redirect controller.
// Takes the EX-stage branch/jump decision, steers fetch to the computed target,
// squashes wrong-path instructions and holds the PC on hazard stalls.
//   clk, reset_n    : clock, async active-low reset
//   stall_i         : hazard unit freezes the PC
//   branch_valid_i  : EX holds a conditional branch; branch_taken_i is its result
//   jump_valid_i    : EX holds JAL/JALR
//   base_pc_i       : EX PC (JAL/branch) or rs1 (JALR); offset_i : immediate
//   pc_o, pc_plus4_o: current fetch address and its successor
//   redirect_o      : redirect accepted this cycle (combinational)
//   flush_ifid_o    : kill IF/ID at next edge; flush_idex_o : kill ID/EX at next edge
//   misalign_o      : one-cycle pulse after a redirect to a target with bit1 set
//   redirect_cnt_o  : saturating count of accepted redirects
module pc_redirect_unit #(
  parameter int              XLEN          = pipe_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC      = pipe_pkg::RESET_PC,
  parameter int              SQUASH_CYCLES = 1,
  parameter int              CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall_i,
  input  logic             branch_valid_i,
  input  logic             branch_taken_i,
  input  logic             jump_valid_i,
  input  logic [XLEN-1:0]  base_pc_i,
  input  logic [XLEN-1:0]  offset_i,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  pc_plus4_o,
  output logic             redirect_o,
  output logic             flush_ifid_o,
  output logic             flush_idex_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);
  import pipe_pkg::*;

  // A zero-cycle squash still needs a legal 1-bit counter.
  localparam int SQ_W = (SQUASH_CYCLES > 0) ? $clog2(SQUASH_CYCLES + 1) : 1;

  redir_state_t    state, state_n;
  logic [SQ_W-1:0] sq_cnt, sq_cnt_n;
  logic [XLEN-1:0] pc_n, target;
  logic            tgt_mis;
  logic            take, redirect, fl_ifid, fl_idex;

  pc_target_calc #(.XLEN(XLEN)) u_tgt (
    .base_i     (base_pc_i),
    .offset_i   (offset_i),
    .target_o   (target),
    .misalign_o (tgt_mis)
  );

  // Jump and taken branch produce the same target, so priority needs no mux.
  assign take       = jump_valid_i | (branch_valid_i & branch_taken_i);
  assign pc_plus4_o = pc_o + XLEN'(4);

  always_comb begin
    state_n  = state;
    sq_cnt_n = sq_cnt;
    pc_n     = pc_o;
    redirect = 1'b0;
    fl_ifid  = 1'b0;
    fl_idex  = 1'b0;
    case (state)
      RUN: begin
        // A redirect wins over stall: whatever is stalled behind it is wrong-path.
        if (take) begin
          redirect = 1'b1;
          fl_ifid  = 1'b1;
          fl_idex  = 1'b1;
          pc_n     = target;
          if (SQUASH_CYCLES > 0) begin
            state_n  = SQUASH;
            sq_cnt_n = SQ_W'(SQUASH_CYCLES);
          end
        end else if (!stall_i) begin
          pc_n = pc_plus4_o;
        end
      end
      SQUASH: begin
        // EX contents here are bubbles or wrong-path, so branch/jump are ignored.
        fl_ifid = 1'b1;
        if (!stall_i) begin
          pc_n     = pc_plus4_o;
          sq_cnt_n = sq_cnt - SQ_W'(1);
          if (sq_cnt == SQ_W'(1)) state_n = RUN;
        end
      end
      default: state_n = RUN;
    endcase
  end

  // RUN-state outputs depend on live inputs, so gate them while reset is held.
  assign redirect_o   = redirect & reset_n;
  assign flush_ifid_o = fl_ifid  & reset_n;
  assign flush_idex_o = fl_idex  & reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= RUN;
      sq_cnt         <= '0;
      pc_o           <= RESET_PC;
      misalign_o     <= 1'b0;
      redirect_cnt_o <= '0;
    end else begin
      state      <= state_n;
      sq_cnt     <= sq_cnt_n;
      pc_o       <= pc_n;
      misalign_o <= redirect & tgt_mis;
      if (redirect && (redirect_cnt_o != {CNT_W{1'b1}}))
        redirect_cnt_o <= redirect_cnt_o + CNT_W'(1);
    end
  end
endmodule
